byte_lane_sched: RTL and testbench

BYTE_LANE_SCHED -- requirements
Module: byte_lane_sched

---
 rtl/byte_lane_sched_pkg.sv | 26 ++
 rtl/byte_lane_sched_if.sv | 30 +++
 rtl/byte_lane_sched_rr_arbiter4.sv | 28 ++
 rtl/byte_lane_sched.sv | 130 +++++++++++++
 tb/tb_byte_lane_sched.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_lane_sched_pkg.sv
// Shared constants, types and state encoding for the byte-lane scheduler.
// The scheduler and its round-robin arbiter both import this package.
package byte_lane_sched_pkg;

    localparam int NLANES     = 4;
    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(NLANES);
    localparam int CNT_W      = $clog2(WORD_BYTES);

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam cnt_t  LAST_BYTE  = cnt_t'(WORD_BYTES - 1);
    // Pointer starts at the top lane so lane 0 wins the first arbitration.
    localparam lane_t LAST_RESET = lane_t'(NLANES - 1);

    function automatic logic [NLANES-1:0] lane_onehot(lane_t lane);
        return {{(NLANES-1){1'b0}}, 1'b1} << lane;
    endfunction

endpackage

// File: rtl/byte_lane_sched_if.sv
// Lane-side and packer-side signals of the byte-lane scheduler.
// The master modport is the environment; the slave modport is the scheduler.
interface byte_lane_sched_if;
    import byte_lane_sched_pkg::*;

    logic [NLANES-1:0] lane_en;
    logic [NLANES-1:0] req;
    logic [7:0]        data_in0;
    logic [7:0]        data_in1;
    logic [7:0]        data_in2;
    logic [7:0]        data_in3;
    logic              hold;
    logic [NLANES-1:0] pop;
    logic [7:0]        data_out;
    logic              valid_out;
    lane_t             lane_out;
    logic              word_start;
    logic              word_end;

    modport master (
        output lane_en, req, data_in0, data_in1, data_in2, data_in3, hold,
        input  pop, data_out, valid_out, lane_out, word_start, word_end
    );

    modport slave (
        input  lane_en, req, data_in0, data_in1, data_in2, data_in3, hold,
        output pop, data_out, valid_out, lane_out, word_start, word_end
    );

endinterface

// File: rtl/byte_lane_sched_rr_arbiter4.sv
// Combinational round-robin pick: searches from last+1 upward, wrapping,
// and returns the first eligible lane plus whether any lane was eligible.
module rr_arbiter4
    import byte_lane_sched_pkg::*;
(
    input  logic [NLANES-1:0] eligible,
    input  lane_t             last,
    output lane_t             winner,
    output logic              any
);

    lane_t idx;

    // Offset NLANES wraps back to last itself, so a lone requester equal to last still wins.
    always_comb begin
        winner = last;
        any    = 1'b0;
        idx    = last;
        for (int k = 1; k <= NLANES; k++) begin
            idx = last + lane_t'(k);
            if (!any && eligible[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_lane_sched.sv
// Grants whole 4-byte words from round-robin-arbitrated byte lanes and streams
// the bytes, registered, to the 8b-to-32b packer.
module byte_lane_sched
    import byte_lane_sched_pkg::*;
(
    input  logic             clk_4f,
    input  logic             reset_L,
    byte_lane_sched_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    cnt_t              cnt;
    cnt_t              cnt_nxt;
    lane_t             gnt;
    lane_t             gnt_nxt;
    lane_t             last;
    lane_t             last_nxt;
    lane_t             arb_last;
    lane_t             winner;
    logic [NLANES-1:0] eligible;
    logic              any;
    logic              pop_any;
    logic [7:0]        lane_byte;

    logic [7:0]        data_reg;
    logic              valid_reg;
    lane_t             lane_reg;
    logic              start_reg;
    logic              end_reg;

    assign eligible = bus.req & bus.lane_en;

    // While a word is in flight, gnt is exactly what last becomes at the word's
    // final byte, so the back-to-back re-arbitration sees the updated pointer.
    assign arb_last = (state == XFER) ? gnt : last;

    rr_arbiter4 u_arb (
        .eligible (eligible),
        .last     (arb_last),
        .winner   (winner),
        .any      (any)
    );

    assign pop_any = (state == XFER) && !bus.hold;
    assign bus.pop = pop_any ? lane_onehot(gnt) : '0;

    always_comb begin
        lane_byte = bus.data_in0;
        case (gnt)
            2'd0:    lane_byte = bus.data_in0;
            2'd1:    lane_byte = bus.data_in1;
            2'd2:    lane_byte = bus.data_in2;
            default: lane_byte = bus.data_in3;
        endcase
    end

    // Once granted, a word runs to completion regardless of req/lane_en.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = XFER;
                    gnt_nxt   = winner;
                    cnt_nxt   = '0;
                end
            end
            XFER: begin
                if (pop_any) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_BYTE) begin
                        last_nxt = gnt;
                        if (any) begin
                            gnt_nxt = winner;
                            cnt_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= '0;
            last  <= LAST_RESET;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            data_reg  <= 8'h00;
            valid_reg <= 1'b0;
            lane_reg  <= '0;
            start_reg <= 1'b0;
            end_reg   <= 1'b0;
        end else if (pop_any) begin
            data_reg  <= lane_byte;
            valid_reg <= 1'b1;
            lane_reg  <= gnt;
            start_reg <= (cnt == '0);
            end_reg   <= (cnt == LAST_BYTE);
        end else begin
            valid_reg <= 1'b0;
            start_reg <= 1'b0;
            end_reg   <= 1'b0;
        end
    end

    assign bus.data_out   = data_reg;
    assign bus.valid_out  = valid_reg;
    assign bus.lane_out   = lane_reg;
    assign bus.word_start = start_reg;
    assign bus.word_end   = end_reg;

endmodule

// File: tb/tb_byte_lane_sched.sv
// Bench for byte_lane_sched: lanes are byte queues, a word-level model predicts
// grants and the byte stream, and directed scenarios precede a random soak.
module tb_byte_lane_sched;
    import byte_lane_sched_pkg::*;

    logic clk_4f  = 1'b0;
    logic reset_L = 1'b1;

    byte_lane_sched_if bus ();

    byte_lane_sched dut (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk_4f = ~clk_4f;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] lane_q [NLANES][$];

    bit         m_busy;
    int         m_cur;
    int         m_sent;
    int         m_last;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ws;
    bit         exp_we;
    int         exp_lane;

    logic       hold_drv;
    logic [3:0] en_drv;

    logic [7:0] obs_bytes[$];
    int         obs_ws_lanes[$];
    int         run_len;
    int         max_run;
    logic [3:0] pop_seen;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] elig, input int from);
        for (int d = 1; d <= NLANES; d++) begin
            if (elig[(from + d) % NLANES]) return (from + d) % NLANES;
        end
        return -1;
    endfunction

    task automatic clear_lanes();
        for (int i = 0; i < NLANES; i++) lane_q[i].delete();
        obs_bytes.delete();
        obs_ws_lanes.delete();
        run_len  = 0;
        max_run  = 0;
        pop_seen = '0;
    endtask

    task automatic push_word(input int lane, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        lane_q[lane].push_back(b0);
        lane_q[lane].push_back(b1);
        lane_q[lane].push_back(b2);
        lane_q[lane].push_back(b3);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        checkOutput("rst_valid_out", 32'(bus.valid_out), 32'd0);
        checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
        checkOutput("rst_lane_out", 32'(bus.lane_out), 32'd0);
        checkOutput("rst_word_start", 32'(bus.word_start), 32'd0);
        checkOutput("rst_word_end", 32'(bus.word_end), 32'd0);
        checkOutput("rst_pop", 32'(bus.pop), 32'd0);
        m_busy    = 1'b0;
        m_cur     = 0;
        m_sent    = 0;
        m_last    = NLANES - 1;
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ws    = 1'b0;
        exp_we    = 1'b0;
        exp_lane  = 0;
        run_len   = 0;
        repeat (2) @(posedge clk_4f);
        #1;
        reset_L = 1'b1;
    endtask

    // One clock: drive lanes, check pop against the model, advance the model
    // across the edge, then check the registered outputs.
    task automatic applyStimulus();
        logic [3:0] req_v;
        logic [7:0] head [NLANES];
        logic [3:0] exp_pop;
        int         w;
        for (int i = 0; i < NLANES; i++) begin
            req_v[i] = (lane_q[i].size() >= WORD_BYTES);
            head[i]  = (lane_q[i].size() > 0) ? lane_q[i][0] : 8'($urandom);
        end
        bus.req      = req_v;
        bus.data_in0 = head[0];
        bus.data_in1 = head[1];
        bus.data_in2 = head[2];
        bus.data_in3 = head[3];
        bus.hold     = hold_drv;
        bus.lane_en  = en_drv;
        #1;
        exp_pop = (m_busy && !hold_drv) ? 4'(1 << m_cur) : 4'b0000;
        checkOutput("pop", 32'(bus.pop), 32'(exp_pop));
        pop_seen |= bus.pop;

        if (m_busy && !hold_drv) begin
            exp_data  = (lane_q[m_cur].size() > 0) ? lane_q[m_cur].pop_front() : 8'hxx;
            exp_valid = 1'b1;
            exp_lane  = m_cur;
            exp_ws    = (m_sent == 0);
            exp_we    = (m_sent == WORD_BYTES - 1);
            m_sent++;
            if (m_sent == WORD_BYTES) begin
                m_last = m_cur;
                m_busy = 1'b0;
            end
        end else begin
            exp_valid = 1'b0;
            exp_ws    = 1'b0;
            exp_we    = 1'b0;
        end
        if (!m_busy) begin
            w = pick(req_v & en_drv, m_last);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_cur  = w;
                m_sent = 0;
            end
        end

        @(posedge clk_4f);
        #1;
        checkOutput("valid_out", 32'(bus.valid_out), 32'(exp_valid));
        checkOutput("word_start", 32'(bus.word_start), 32'(exp_ws));
        checkOutput("word_end", 32'(bus.word_end), 32'(exp_we));
        checkOutput("data_out", 32'(bus.data_out), 32'(exp_data));
        checkOutput("lane_out", 32'(bus.lane_out), 32'(exp_lane));
        if (bus.valid_out) begin
            obs_bytes.push_back(bus.data_out);
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (bus.word_start) obs_ws_lanes.push_back(int'(bus.lane_out));
    endtask

    initial begin
        int stall;
        bit stall_done;

        hold_drv     = 1'b0;
        en_drv       = 4'b1111;
        bus.req      = '0;
        bus.lane_en  = en_drv;
        bus.hold     = 1'b0;
        bus.data_in0 = 8'h00;
        bus.data_in1 = 8'h00;
        bus.data_in2 = 8'h00;
        bus.data_in3 = 8'h00;
        clear_lanes();
        do_reset();

        $display("[TB] single lane word");
        do_reset();
        clear_lanes();
        push_word(0, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        repeat (8) applyStimulus();
        checkOutput("single_count", 32'(obs_bytes.size()), 32'd4);
        if (obs_bytes.size() == 4) begin
            checkOutput("single_b0", 32'(obs_bytes[0]), 32'hA0);
            checkOutput("single_b3", 32'(obs_bytes[3]), 32'hA3);
        end
        checkOutput("single_words", 32'(obs_ws_lanes.size()), 32'd1);

        $display("[TB] all lanes back to back");
        do_reset();
        clear_lanes();
        push_word(0, 8'h00, 8'h01, 8'h02, 8'h03);
        push_word(0, 8'h04, 8'h05, 8'h06, 8'h07);
        push_word(1, 8'h10, 8'h11, 8'h12, 8'h13);
        push_word(2, 8'h20, 8'h21, 8'h22, 8'h23);
        push_word(3, 8'h30, 8'h31, 8'h32, 8'h33);
        repeat (26) applyStimulus();
        checkOutput("all_contiguous", 32'(max_run), 32'd20);
        checkOutput("all_words", 32'(obs_ws_lanes.size()), 32'd5);
        if (obs_ws_lanes.size() == 5) begin
            for (int i = 0; i < 5; i++)
                checkOutput("all_order", 32'(obs_ws_lanes[i]), 32'(i % NLANES));
        end

        $display("[TB] stall after byte 1");
        do_reset();
        clear_lanes();
        push_word(2, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
        stall      = 0;
        stall_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (!stall_done && m_busy && m_cur == 2 && m_sent == 2) begin
                stall      = 3;
                stall_done = 1'b1;
            end
            hold_drv = (stall > 0);
            if (stall > 0) stall--;
            applyStimulus();
        end
        hold_drv = 1'b0;
        checkOutput("stall_seen", 32'(stall_done), 32'd1);
        checkOutput("stall_count", 32'(obs_bytes.size()), 32'd4);
        if (obs_bytes.size() == 4) begin
            for (int i = 0; i < 4; i++)
                checkOutput("stall_byte", 32'(obs_bytes[i]), 32'(8'hC0 + i));
        end

        $display("[TB] lane enable mask");
        do_reset();
        clear_lanes();
        en_drv = 4'b1011;
        push_word(1, 8'h51, 8'h52, 8'h53, 8'h54);
        push_word(2, 8'h61, 8'h62, 8'h63, 8'h64);
        repeat (12) applyStimulus();
        checkOutput("mask_lane2_pop", 32'(pop_seen[2]), 32'd0);
        checkOutput("mask_words", 32'(obs_ws_lanes.size()), 32'd1);
        if (obs_ws_lanes.size() == 1) checkOutput("mask_lane", 32'(obs_ws_lanes[0]), 32'd1);
        en_drv = 4'b1111;

        $display("[TB] reset mid word");
        do_reset();
        clear_lanes();
        push_word(3, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
        for (int c = 0; c < 10 && obs_bytes.size() < 2; c++) applyStimulus();
        checkOutput("rst_mid_reached_byte1", 32'(obs_bytes.size()), 32'd2);
        do_reset();
        clear_lanes();
        push_word(3, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
        repeat (8) applyStimulus();
        checkOutput("rst_mid_count", 32'(obs_bytes.size()), 32'd4);
        if (obs_bytes.size() == 4) checkOutput("rst_mid_first", 32'(obs_bytes[0]), 32'hE0);
        checkOutput("rst_mid_words", 32'(obs_ws_lanes.size()), 32'd1);
        if (obs_ws_lanes.size() == 1) checkOutput("rst_mid_lane", 32'(obs_ws_lanes[0]), 32'd3);

        $display("[TB] random soak");
        do_reset();
        clear_lanes();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NLANES; i++) begin
                if ($urandom_range(0, 7) == 0 && lane_q[i].size() < 12)
                    push_word(i, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end
            hold_drv = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) en_drv = 4'($urandom);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
